// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand/result handshake bundle for muldiv_unit.
// The requester side (pipeline) uses the master modport; the unit uses slave.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             busy;

    modport master (
        output in_valid,
        output op_div,
        output op_signed,
        output operand_a,
        output operand_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  exception,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  op_div,
        input  op_signed,
        input  operand_a,
        input  operand_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output exception,
        output busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide engine with valid/ready handshake.
// Shift-add multiply and restoring divide run on operand magnitudes, STEP
// bits retired per RUN cycle; sign and overflow are resolved on the cycle
// that enters DONE, so result/exception are plain registers while DONE.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- a multiply leaves RUN as
// soon as the remaining multiplier magnitude bits are all zero.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    muldiv_unit_if.slave bus
);
    localparam int ITERS = WIDTH / STEP;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Control state (asynchronously reset)
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;

    // Datapath state (loaded on accept, no reset needed)
    logic             r_op_div;
    logic             r_signed;
    logic             r_neg;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_mcand_sh;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_dvsr;

    // Magnitude of a possibly two's-complement operand. MIN_INT maps to
    // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x,
                                               input logic             sgn);
        logic signed [WIDTH-1:0] sx;
        sx = x;
        return (sgn && (sx < 0)) ? WIDTH'(-sx) : x;
    endfunction

    // One multiply iteration: add the shifted multiplicand for each set
    // multiplier bit in this STEP-wide slice.
    function automatic logic [ACC_W-1:0] f_mul_step(input logic [ACC_W-1:0] acc,
                                                    input logic [ACC_W-1:0] mcand_sh,
                                                    input logic [STEP-1:0]  bits);
        logic [ACC_W-1:0] sum;
        sum = acc;
        for (int k = 0; k < STEP; k++) begin
            if (bits[k]) begin
                sum = sum + (mcand_sh << k);
            end
        end
        return sum;
    endfunction

    // One restoring-divide iteration producing STEP quotient bits.
    // Returns {remainder, shifted dividend/quotient}.
    function automatic logic [2*WIDTH-1:0] f_div_step(input logic [WIDTH-1:0] rem,
                                                      input logic [WIDTH-1:0] quot,
                                                      input logic [WIDTH-1:0] dvsr);
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] q;
        r = rem;
        q = quot;
        for (int k = 0; k < STEP; k++) begin
            trial = {r, q[WIDTH-1]};
            q     = {q[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, dvsr}) begin
                trial = trial - {1'b0, dvsr};
                q[0]  = 1'b1;
            end
            r = trial[WIDTH-1:0];
        end
        return {r, q};
    endfunction

    // Apply the product sign and flag products that do not fit in WIDTH
    // bits. Returns {overflow, low WIDTH bits}.
    function automatic logic [WIDTH:0] f_mul_final(input logic [ACC_W-1:0] mag,
                                                   input logic             neg,
                                                   input logic             sgn);
        logic signed [ACC_W-1:0] p;
        logic                    ovf;
        p = neg ? -$signed(mag) : $signed(mag);
        if (sgn) begin
            ovf = !((&p[ACC_W-1:WIDTH-1]) || !(|p[ACC_W-1:WIDTH-1]));
        end else begin
            ovf = |mag[ACC_W-1:WIDTH];
        end
        return {ovf, p[WIDTH-1:0]};
    endfunction

    // Apply the quotient sign. The only signed overflow is MIN_INT / -1,
    // where the positive quotient magnitude is 2^(WIDTH-1); its low bits
    // already read back as MIN_INT.
    function automatic logic [WIDTH:0] f_div_final(input logic [WIDTH-1:0] q,
                                                   input logic             neg,
                                                   input logic             sgn);
        logic signed [WIDTH-1:0] r;
        r = neg ? -$signed(q) : $signed(q);
        return {sgn && !neg && q[WIDTH-1], r};
    endfunction

    logic             w_accept;
    logic             w_div0;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [ACC_W-1:0] w_mcand_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic             w_last;
    logic [WIDTH:0]   w_fin;

    assign w_accept     = (r_state == S_IDLE) && bus.in_valid && !flush;
    assign w_div0       = bus.op_div && (bus.operand_b == '0);
    assign w_a_mag      = f_mag(bus.operand_a, bus.op_signed);
    assign w_b_mag      = f_mag(bus.operand_b, bus.op_signed);
    assign w_neg        = bus.op_signed && (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);

    assign w_acc_nxt    = f_mul_step(r_acc, r_mcand_sh, r_mplier[STEP-1:0]);
    assign w_mplier_nxt = r_mplier >> STEP;
    assign w_mcand_nxt  = r_mcand_sh << STEP;
    assign w_div_nxt    = f_div_step(r_rem, r_quot, r_dvsr);

`ifdef MULDIV_EARLY_OUT_EN
    // A multiply is finished once no set multiplier bits remain; the
    // current iteration always runs, so RUN lasts at least one cycle.
    assign w_last = (r_cnt == '0) || (!r_op_div && (w_mplier_nxt == '0));
`else
    assign w_last = (r_cnt == '0);
`endif

    assign w_fin = r_op_div ? f_div_final(w_div_nxt[WIDTH-1:0], r_neg, r_signed)
                            : f_mul_final(w_acc_nxt, r_neg, r_signed);

    // Datapath: load magnitudes on accept, advance one iteration per RUN cycle
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_op_div   <= bus.op_div;
            r_signed   <= bus.op_signed;
            r_neg      <= w_neg;
            r_acc      <= '0;
            r_mcand_sh <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier   <= w_b_mag;
            r_rem      <= '0;
            r_quot     <= w_a_mag;
            r_dvsr     <= w_b_mag;
        end else if (r_state == S_RUN) begin
            r_acc      <= w_acc_nxt;
            r_mcand_sh <= w_mcand_nxt;
            r_mplier   <= w_mplier_nxt;
            r_rem      <= w_div_nxt[2*WIDTH-1:WIDTH];
            r_quot     <= w_div_nxt[WIDTH-1:0];
        end
    end

    // Control FSM with registered handshake outputs and result capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_exc       <= 1'b0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_div0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= '0;
                            r_exc       <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_cnt   <= CNT_W'(ITERS - 1);
                        end
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_fin[WIDTH-1:0];
                        r_exc       <= w_fin[WIDTH];
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.exception = r_exc;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, randomized ops against an arithmetic
// reference model, and hand-written backpressure/reset/flush sequences.
module tb_muldiv_unit;
    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .STEP(1)) dut (
        .clock (clk),
        .reset (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        d;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Arithmetic reference: full-precision product / truncating quotient.
    function automatic void ref_op(input logic d, input logic s,
                                   input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
        longint sa, sb, p;
        longint unsigned up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (d) begin
            if (b == 0) begin
                r = 0; e = 1'b1;
            end else if (s) begin
                p = sa / sb;
                r = p[31:0];
                e = (p > SMAX);
            end else begin
                r = a / b; e = 1'b0;
            end
        end else begin
            if (s) begin
                p = sa * sb;
                r = p[31:0];
                e = (p > SMAX) || (p < SMIN);
            end else begin
                up = {32'b0, a} * {32'b0, b};
                r = up[31:0];
                e = (up[63:32] != 0);
            end
        end
    endfunction

    // Edges from the accept edge to the first edge that sees out_valid high.
    function automatic int ref_lat(input logic d, input logic s, input logic [31:0] b);
        logic [31:0] m;
        int n;
        if (d && b == 0) return 1;
        if (d) return W + 1;
`ifdef MULDIV_EARLY_OUT_EN
        m = (s && b[31]) ? (32'd0 - b) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        return 1 + ((n < 1) ? 1 : n);
`else
        m = b;
        n = s ? 0 : int'(m[0]);
        return W + 1 + n - n;
`endif
    endfunction

    task automatic issue(input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op_div    = d;
        bus.op_signed = s;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_check(input string name, input logic d, input logic s,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] er, input logic ee);
        int lat;
        issue(d, s, a, b);
        wait_out(lat);
        chk({name, ".latency"}, lat, ref_lat(d, s, b));
        chk({name, ".result"}, bus.result, er);
        chk({name, ".exception"}, bus.exception, ee);
        @(posedge clk); #1;
        chk({name, ".in_ready_after"}, {bus.in_ready, bus.out_valid}, 2'b10);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic d, s, ee;
        logic [31:0] a, b, er;
        int lat;
        bit seen;

        vecs[0]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'd5,        32'd0,        32'h0,        1'b1};
        vecs[4]  = '{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 32'h00010000, 32'h00010000, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h80000000, 32'd1,        32'h80000000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 32'd1234,     32'd1,        32'd1234,     1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'd0,        32'd0,        32'd0,        1'b1};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_div    = 1'b0;
        bus.op_signed = 1'b0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready",  bus.in_ready,  1'b1);
        chk("reset.out_valid", bus.out_valid, 1'b0);
        chk("reset.busy",      bus.busy,      1'b0);
        chk("reset.result",    bus.result,    32'h0);
        chk("reset.exception", bus.exception, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].d, vecs[i].s, vecs[i].a,
                      vecs[i].b, vecs[i].r, vecs[i].e);
        end

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 20));
                2: b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = (i % 5 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            ref_op(d, s, a, b, er, ee);
            run_check($sformatf("rand%0d", i), d, s, a, b, er, ee);
        end

        // Backpressure: result held, new in_valid ignored while DONE
        bus.out_ready = 1'b0;
        issue(1'b0, 1'b0, 32'd1000, 32'd3000);
        wait_out(lat);
        chk("bp.out_valid", bus.out_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.op_div    = 1'b1;
            bus.operand_a = 32'd9;
            bus.operand_b = 32'd3;
            @(posedge clk); #1;
            chk($sformatf("bp%0d.hold", k),
                {bus.out_valid, bus.in_ready, bus.exception, bus.result},
                {1'b1, 1'b0, 1'b0, 32'd3000000});
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);

        // Asynchronous reset mid-RUN, then a correct follow-up op
        issue(1'b0, 1'b1, 32'h12345678, 32'h00000765);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid.state", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        chk("rst_mid.result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_check("after_rst", 1'b0, 1'b1, 32'hFFFFFFFB, 32'd6, 32'hFFFFFFE2, 1'b0);

        // Flush mid-RUN: back to IDLE, no out_valid pulse
        issue(1'b1, 1'b0, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_run.state", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_run.no_out_valid", seen, 1'b0);
        run_check("after_flush", 1'b1, 1'b0, 32'd1000, 32'd7, 32'd142, 1'b0);

        // Flush in IDLE suppresses the accept
        @(negedge clk);
        flush         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_div    = 1'b0;
        bus.operand_a = 32'd3;
        bus.operand_b = 32'd4;
        @(posedge clk); #1;
        chk("flush_idle.busy", {bus.busy, bus.in_ready}, 2'b01);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_idle.still_idle", {bus.busy, bus.out_valid}, 2'b00);

        // Flush in DONE wins over out_ready
        bus.out_ready = 1'b0;
        issue(1'b1, 1'b0, 32'd5, 32'd0);
        wait_out(lat);
        chk("flush_done.pre", {bus.out_valid, bus.exception}, 2'b11);
        @(negedge clk);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("flush_done.state", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
        @(negedge clk);
        flush = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
